debounce_sync: RTL and testbench

- Conditions a raw asynchronous level `inp` into a clean, glitch-free level `out`.
- Sits directly upstream of the rising, falling and both-edge detectors; its `out` drives their `inp`.
- Combines a 2-flop synchronizer, a stability counter and a 4-state FSM.
- Counts rejected glitches for debug.

---
 rtl/debounce_sync_if.sv | 30 +++
 rtl/debounce_sync.sv | 125 ++++++++++++
 tb/tb_debounce_sync.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/debounce_sync_if.sv
// Signal bundle between a debounce_sync instance and its user.
//   inp        : raw asynchronous level to be conditioned
//   clr        : synchronous clear of the glitch counter
//   out        : debounced, registered level
//   busy       : high while a level change is being qualified
//   glitch_cnt : saturating count of rejected transitions
// master drives inp/clr and observes the rest; slave is the debouncer.
interface debounce_sync_if;
  logic       inp;
  logic       clr;
  logic       out;
  logic       busy;
  logic [7:0] glitch_cnt;

  modport master (
    output inp,
    output clr,
    input  out,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  inp,
    input  clr,
    output out,
    output busy,
    output glitch_cnt
  );
endinterface

// File: rtl/debounce_sync.sv
// Debouncer: 2-flop synchronizer, stability counter and 4-state FSM. A new
// level must be seen on the synchronized sample for STABLE_CYCLES consecutive
// edges before out follows it; shorter excursions are dropped and counted.
//   clk   : system clock, rising edge
//   rst_n : synchronous, active-low reset
//   bus   : slave side of debounce_sync_if (inp, clr in; out, busy, glitch_cnt out)
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic             clk,
  input logic             rst_n,
  debounce_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    StStableLow,
    StChkHigh,
    StStableHigh,
    StChkLow
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES) - 64'd1) begin : gen_cnt_w_check
    $error("debounce_sync: CNT_W too narrow to hold STABLE_CYCLES-1");
  end
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : gen_stable_check
    $error("debounce_sync: STABLE_CYCLES outside 2..255");
  end

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic [7:0]       glitch_cnt_q, glitch_cnt_d;
  logic             glitch;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      cnt_q        <= '0;
      state_q      <= StStableLow;
      out_q        <= 1'b0;
      busy_q       <= 1'b0;
      glitch_cnt_q <= 8'd0;
    end else begin
      s1_q         <= bus.inp;
      s2_q         <= s1_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  // Next-state logic; only the synchronized s2_q is ever examined
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    glitch  = 1'b0;
    unique case (state_q)
      StStableLow: begin
        if (s2_q) begin
          state_d = StChkHigh;
          cnt_d   = CNT_W'(1);
        end
      end
      StChkHigh: begin
        if (!s2_q) begin
          state_d = StStableLow;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHigh;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStableHigh: begin
        if (!s2_q) begin
          state_d = StChkLow;
          cnt_d   = CNT_W'(1);
        end
      end
      StChkLow: begin
        if (s2_q) begin
          state_d = StStableHigh;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLow;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StStableLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_comb begin
    out_d        = (state_d == StStableHigh) || (state_d == StChkLow);
    busy_d       = (state_d == StChkHigh) || (state_d == StChkLow);
    glitch_cnt_d = glitch_cnt_q;
    if (bus.clr) begin
      glitch_cnt_d = 8'd0;
    end else if (glitch && glitch_cnt_q != 8'hff) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  assign bus.out        = out_q;
  assign bus.busy       = busy_q;
  assign bus.glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync (STABLE_CYCLES=4).
// Inputs change just after a falling edge; outputs are sampled there too.
module tb_debounce_sync;

  localparam int HalfPeriod = 4;
  localparam int BounceStep = 14;  // 1.75 clock periods

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rise_cnt = 0;
  logic out_prev = 1'b0;

  debounce_sync_if bus ();

  debounce_sync #(
    .STABLE_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #HalfPeriod clk = ~clk;
  end

  // Downstream rising-edge detector model
  always @(posedge clk) begin
    out_prev <= bus.out;
    if (bus.out && !out_prev) rise_cnt <= rise_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic lvl, input int width, input int gap);
    bus.inp = lvl;
    cyc(width);
    bus.inp = ~lvl;
    cyc(gap);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
  endtask

  initial begin
    logic seen_high;
    int   r0;

    // 1: reset and clean rising step
    rst_n   = 1'b0;
    bus.inp = 1'b0;
    bus.clr = 1'b0;
    cyc(3);
    check("rst_out", 32'(bus.out), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_gc", 32'(bus.glitch_cnt), 0);
    rst_n = 1'b1;
    cyc(2);
    bus.inp = 1'b1;
    cyc(1);  // E0
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check($sformatf("t1_out_e%0d", k), 32'(bus.out), 32'(k >= 5));
      check($sformatf("t1_busy_e%0d", k), 32'(bus.busy), 32'(k >= 2 && k <= 4));
    end
    check("t1_gc", 32'(bus.glitch_cnt), 0);

    // 4: falling path with a CHK_LOW glitch, then a real fall
    do_clr();
    bus.inp = 1'b0;
    cyc(2);
    bus.inp = 1'b1;
    cyc(1);
    check("t4_busy_chk", 32'(bus.busy), 1);
    check("t4_out_chk", 32'(bus.out), 1);
    cyc(2);
    check("t4_busy_rej", 32'(bus.busy), 0);
    check("t4_gc", 32'(bus.glitch_cnt), 1);
    cyc(4);
    check("t4_out_hold", 32'(bus.out), 1);
    bus.inp = 1'b0;
    cyc(5);  // E0..E0+4
    check("t4_out_e4", 32'(bus.out), 1);
    check("t4_busy_e4", 32'(bus.busy), 1);
    cyc(1);
    check("t4_out_e5", 32'(bus.out), 0);
    check("t4_busy_e5", 32'(bus.busy), 0);

    // 2: bounce train, 16 toggles at 1.75-period spacing ending low
    do_clr();
    seen_high = 1'b0;
    fork
      begin
        #1;
        repeat (16) begin
          bus.inp = ~bus.inp;
          #BounceStep;
        end
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (bus.out !== 1'b0) seen_high = 1'b1;
        end
      end
    join
    check("t2_out_never_high", 32'(seen_high), 0);
    cyc(12);
    check("t2_gc", 32'(bus.glitch_cnt), 8);
    check("t2_busy", 32'(bus.busy), 0);
    check("t2_out", 32'(bus.out), 0);

    // 3: three 1-cycle high pulses, then settle high
    do_clr();
    r0 = rise_cnt;
    repeat (3) pulse(1'b1, 1, 3);
    bus.inp = 1'b1;
    cyc(1);  // E0
    cyc(4);
    check("t3_out_e4", 32'(bus.out), 0);
    cyc(1);
    check("t3_out_e5", 32'(bus.out), 1);
    check("t3_gc", 32'(bus.glitch_cnt), 3);
    cyc(4);
    check("t3_rise_pulses", 32'(rise_cnt - r0), 1);

    // 5: saturation, then clr against a coincident glitch
    do_clr();
    repeat (300) pulse(1'b0, 1, 3);
    check("t5_gc_sat", 32'(bus.glitch_cnt), 255);
    check("t5_out", 32'(bus.out), 1);
    bus.inp = 1'b0;
    cyc(1);
    bus.inp = 1'b1;
    cyc(2);
    check("t5_busy_pre", 32'(bus.busy), 1);
    bus.clr = 1'b1;
    cyc(1);  // glitch edge
    bus.clr = 1'b0;
    check("t5_gc_clr", 32'(bus.glitch_cnt), 0);
    check("t5_busy_post", 32'(bus.busy), 0);
    pulse(1'b0, 1, 3);
    check("t5_gc_after", 32'(bus.glitch_cnt), 1);

    // 6: reset in the middle of a check
    rst_n   = 1'b0;
    bus.inp = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    check("t6_out_rst", 32'(bus.out), 0);
    bus.inp = 1'b1;
    cyc(1);  // E0
    cyc(3);  // CHK_HIGH, cnt=2
    check("t6_busy_mid", 32'(bus.busy), 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("t6_out_abort", 32'(bus.out), 0);
    check("t6_busy_abort", 32'(bus.busy), 0);
    check("t6_gc_abort", 32'(bus.glitch_cnt), 0);
    cyc(1);  // first post-reset capture
    cyc(4);
    check("t6_out_e4", 32'(bus.out), 0);
    check("t6_busy_e4", 32'(bus.busy), 1);
    cyc(1);
    check("t6_out_e5", 32'(bus.out), 1);
    check("t6_busy_e5", 32'(bus.busy), 0);
    check("t6_gc_end", 32'(bus.glitch_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
